// File: rtl/atta_trace_uart.sv
// Trace word sink: buffers 36-bit CPU trace words in a FIFO and ships each one
// as a five-byte 8N1 UART frame, first byte tagged with 4'hA.
module atta_trace_uart #(
    parameter int CLK_DIV = 868,
    parameter int FIFO_AW = 4
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               trace_valid_i,
    input  logic [35:0]        trace_data_i,
    input  logic               enable_i,
    output logic               uart_tx_o,
    output logic               busy_o,
    output logic               overflow_o,
    output logic [15:0]        drop_cnt_o,
    output logic [FIFO_AW:0]   fifo_level_o
);
    // state | meaning
    // IDLE  | line high, waiting for a queued word and enable_i
    // START | start bit of the current byte
    // DATA  | eight data bits, LSB first
    // STOP  | stop bit; after byte 4 leaves one cycle early so IDLE completes it
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam int          DEPTH    = 2 ** FIFO_AW;
    localparam logic [15:0] BIT_LAST = 16'(CLK_DIV - 1);

    logic [35:0]        mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;

    state_t      state;
    logic [15:0] timer;
    logic [39:0] shreg;
    logic [6:0]  bit_sh;
    logic [2:0]  bit_idx;
    logic [2:0]  byte_idx;

    assign full  = (fifo_level_o == (FIFO_AW + 1)'(DEPTH));
    assign empty = (fifo_level_o == '0);
    assign push  = trace_valid_i && !full;
    assign pop   = (state == IDLE) && !empty && enable_i;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= trace_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_level_o <= '0;
            overflow_o   <= 1'b0;
            drop_cnt_o   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_level_o <= fifo_level_o + 1'b1;
                2'b01:   fifo_level_o <= fifo_level_o - 1'b1;
                default: fifo_level_o <= fifo_level_o;
            endcase
            // Full is judged before the pop, so a write while full is always lost
            if (trace_valid_i && full) begin
                overflow_o <= 1'b1;
                if (drop_cnt_o != 16'hFFFF) begin
                    drop_cnt_o <= drop_cnt_o + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= IDLE;
            uart_tx_o <= 1'b1;
            busy_o    <= 1'b0;
            timer     <= '0;
            shreg     <= '0;
            bit_sh    <= '0;
            bit_idx   <= '0;
            byte_idx  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        shreg     <= {4'hA, mem[rd_ptr]};
                        byte_idx  <= '0;
                        uart_tx_o <= 1'b0;
                        busy_o    <= 1'b1;
                        timer     <= BIT_LAST;
                        state     <= START;
                    end
                end
                START: begin
                    if (timer == '0) begin
                        uart_tx_o <= shreg[32];
                        bit_sh    <= shreg[39:33];
                        shreg     <= {shreg[31:0], 8'h00};
                        bit_idx   <= '0;
                        timer     <= BIT_LAST;
                        state     <= DATA;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                DATA: begin
                    if (timer == '0) begin
                        timer <= BIT_LAST;
                        if (bit_idx == 3'd7) begin
                            uart_tx_o <= 1'b1;
                            state     <= STOP;
                        end else begin
                            uart_tx_o <= bit_sh[0];
                            bit_sh    <= {1'b0, bit_sh[6:1]};
                            bit_idx   <= bit_idx + 3'd1;
                        end
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                STOP: begin
                    if (byte_idx == 3'd4 && timer == 16'd1) begin
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end else if (timer == '0) begin
                        uart_tx_o <= 1'b0;
                        byte_idx  <= byte_idx + 3'd1;
                        timer     <= BIT_LAST;
                        state     <= START;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
